logic_op_issue: RTL
===================

Name: logic_op_issue

Overview:
- Issue/execute stage directly upstream of the bitwise result consumers. It buffers incoming {opcode, operand A, operand B} requests in a small FIFO.
- Performs the selected bitwise operation on the FIFO head and holds the result in an output register under a valid/ready handshake.
- Decouples the request producer from a possibly stalled result consumer and counts illegal opcodes.

Parameters:
- K, 8, operand/result width in bits
- DEPTH, 4, request FIFO entries (power of two, >= 2)
- CW, 3, fifo_count width, equal to log2(DEPTH)+1

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  FIFO can accept a request this cycle
- in_op  input  3  opcode: 000 AND, 001 OR, 010 XOR, 011 PASS_A, 1xx illegal
- in_a  input  K  operand A
- in_b  input  K  operand B
- out_valid  output  1  result register holds a valid result
- out_ready  input  1  consumer accepts the result this cycle
- out_result  output  K  registered result
- out_err  output  1  registered flag: the result came from an illegal opcode
- fifo_count  output  CW  number of occupied FIFO entries
- err_cnt  output  8  saturating count of illegal opcodes issued

Behaviour:
- Reset (rst=1 at an edge): FIFO emptied (read ptr = write ptr = 0, count 0), out_valid=0, out_result=0, out_err=0, err_cnt=0. in_ready=1 in the cycle after reset.
- Reset mid-operation discards all queued and held requests. No partial results appear afterwards.
- Push: in_valid && in_ready at an edge writes {op,a,b} at the write pointer. The write pointer wraps from DEPTH-1 to 0.
- in_ready = (fifo_count != DEPTH). This is purely a function of registered count. No push is accepted when full, even if a pop occurs in the same cycle.
- Issue condition: fifo_count != 0 && (!out_valid || out_ready).
- On issue at an edge:
  - The head is popped and the read pointer wraps modulo DEPTH.
  - out_result <= op(a,b); out_err <= op[2]; out_valid <= 1.
- Ops:
  - AND: a&b.
  - OR: a|b.
  - XOR: a^b.
  - PASS_A: a.
  - Illegal (1xx): result all-zeros, out_err=1.
- err_cnt increments by 1 on each issue of an illegal opcode and saturates at 255.
- When out_valid && out_ready and the FIFO is empty: out_valid <= 0. out_result and out_err hold their last values.
- When out_valid && !out_ready: out_result and out_err are held stable and no issue occurs (backpressure).
- Simultaneous push and pop (not full, not empty): count unchanged and both pointers advance.
- Push into an empty FIFO: the entry is not bypassed. It issues at the next edge at the earliest.
- Latency: a request accepted at edge N appears on out_result with out_valid=1 after edge N+1 (2-cycle minimum).
- Throughput: 1 result per cycle while out_ready=1 and the FIFO is non-empty.
- fifo_count = pushes - pops, in the range 0..DEPTH.
- Outputs are registers or decoded from registers only. There is no combinational path from in_* to out_*.
- There is no combinational path from out_ready to in_ready.

Test Plan:
- Reset, then push op=000 a=8'hF0 b=8'h3C with out_ready=1 -> out_valid rises 2 edges after acceptance, out_result=8'h30, out_err=0, then out_valid=0.
- Back-to-back pushes of OR (8'hF0,8'h0F), XOR (8'hFF,8'h0F), PASS_A (8'hA5,8'h00) with out_ready=1 -> results 8'hFF, 8'hF0, 8'hA5 on consecutive cycles, in order.
- Hold out_ready=0 and push 5 requests -> the first issues to the output register and the next 4 fill the FIFO. fifo_count=4, in_ready=0, the 6th in_valid is not accepted, and out_result stays stable. Release out_ready -> all 5 drain in order.
- Push op=3'b101 a=8'hFF b=8'hFF -> out_result=8'h00, out_err=1, err_cnt=1. 260 illegal ops -> err_cnt=255.
- Push/pop wrap: stream 10 requests with out_ready toggling 1,0,1,0 -> no loss or reorder across pointer wrap, and fifo_count never exceeds 4.
- Assert rst with 3 queued entries and out_valid=1 -> next cycle out_valid=0, fifo_count=0, in_ready=1, err_cnt=0, and no stale results afterwards.

Source files
------------

// File: rtl/logic_op_issue.sv
// Issue/execute stage: buffers {opcode, A, B} requests in a small FIFO and
// registers the bitwise result of the head entry under a valid/ready handshake.
module logic_op_issue #(
    parameter int K     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [K-1:0]  in_a,
    input  logic [K-1:0]  in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [K-1:0]  out_result,
    output logic          out_err,
    output logic [CW-1:0] fifo_count,
    output logic [7:0]    err_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_PASS = 3'b011
    } op_e;

    typedef struct packed {
        logic [2:0]   op;
        logic [K-1:0] a;
        logic [K-1:0] b;
    } req_t;

    req_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;
    logic [K-1:0]  out_result_q, out_result_d;
    logic          out_err_q, out_err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic          push;
    logic          issue;
    req_t          head;
    req_t          wr_entry;
    logic [K-1:0]  op_result;

    // in_ready depends only on the registered count, never on out_ready.
    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign issue    = (count_q != '0) && (!out_valid_q || out_ready);
    assign head     = mem_q[rd_ptr_q];
    assign wr_entry = '{op: in_op, a: in_a, b: in_b};

    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise an
        // unassigned path would infer a latch.
        op_result = '0;
        case (head.op)
            OP_AND:  op_result = head.a & head.b;
            OP_OR:   op_result = head.a | head.b;
            OP_XOR:  op_result = head.a ^ head.b;
            OP_PASS: op_result = head.a;
            default: op_result = '0;
        endcase
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + CW'(push) - CW'(issue);
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_err_d    = out_err_q;
        err_cnt_d    = err_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        if (issue) begin
            rd_ptr_d     = rd_ptr_q + AW'(1);
            out_valid_d  = 1'b1;
            out_result_d = op_result;
            out_err_d    = head.op[2];
            if (head.op[2] && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end else if (out_ready) begin
            // Result consumed with nothing queued behind it; data is held.
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_err_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_err_q    <= out_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count guarantee no entry is read before it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_err    = out_err_q;
    assign fifo_count = count_q;
    assign err_cnt    = err_cnt_q;

endmodule
